// File: rtl/vpe_op_scheduler.sv
// vpe_op_scheduler: round-robin, burst-granted sharing of one fixed-latency SIMD PE;
// the op only changes once the pipe has drained, and every result carries its requester id.
module vpe_op_scheduler #(
  parameter int NUM_REQ   = 4,
  parameter int PHIT      = 512,
  parameter int SIMD      = 16,
  parameter int LAT       = 4,
  parameter int OPW       = 3,
  parameter int MAX_BURST = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ*OPW-1:0]       req_op,
  input  logic [NUM_REQ-1:0]           req_last,
  input  logic [NUM_REQ*PHIT-1:0]      req_data1,
  input  logic [NUM_REQ*PHIT-1:0]      req_data2,
  input  logic [NUM_REQ*SIMD-1:0]      req_lanes,
  output logic [NUM_REQ-1:0]           req_ready,
  output logic [PHIT-1:0]              pe_in1,
  output logic [PHIT-1:0]              pe_in2,
  output logic [SIMD-1:0]              pe_tvalid1,
  output logic [SIMD-1:0]              pe_tvalid2,
  output logic [OPW-1:0]               pe_op,
  output logic                         res_valid,
  output logic [$clog2(NUM_REQ)-1:0]   res_id,
  output logic                         busy
);
  localparam int IDW = $clog2(NUM_REQ);
  localparam int CW  = $clog2(MAX_BURST + 1);
  typedef enum logic [1:0] {ARB, DRAIN, ISSUE} state_t;
  state_t state_q, state_d;
  logic [IDW-1:0] rr_ptr_q, rr_ptr_d, grant_q, grant_d, winner;
  logic [OPW-1:0] pe_op_q, pe_op_d, win_op, grant_op;
  logic [CW-1:0] beat_cnt_q, beat_cnt_d;
  logic [LAT-1:0] tag_v_q, tag_v_d;
  logic [LAT-1:0][IDW-1:0] tag_id_q, tag_id_d;
  logic pipe_empty, accept, burst_end, go, issue;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ARB;
      rr_ptr_q   <= '0;
      grant_q    <= '0;
      pe_op_q    <= '0;
      beat_cnt_q <= '0;
      tag_v_q    <= '0;
      tag_id_q   <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      grant_q    <= grant_d;
      pe_op_q    <= pe_op_d;
      beat_cnt_q <= beat_cnt_d;
      tag_v_q    <= tag_v_d;
      tag_id_q   <= tag_id_d;
    end
  end
  // Descending scan so the closest requester at or after rr_ptr wins.
  always_comb begin
    winner = rr_ptr_q;
    for (int k = NUM_REQ - 1; k >= 0; k--)
      if (req_valid[(int'(rr_ptr_q) + k) % NUM_REQ]) winner = IDW'((int'(rr_ptr_q) + k) % NUM_REQ);
  end
  always_comb begin
    win_op     = req_op[winner*OPW +: OPW];
    grant_op   = req_op[grant_q*OPW +: OPW];
    pipe_empty = ~|tag_v_q;
    go         = (win_op == pe_op_q) || pipe_empty;
    accept     = (state_q == ISSUE) && req_valid[grant_q];
    burst_end  = accept && (req_last[grant_q] || beat_cnt_q == CW'(MAX_BURST - 1));
    tag_v_d    = LAT'({tag_v_q, accept});
    tag_id_d   = (LAT*IDW)'({tag_id_q, grant_q});
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    grant_d    = grant_q;
    pe_op_d    = pe_op_q;
    beat_cnt_d = beat_cnt_q;
    case (state_q)
      ARB: if (|req_valid) begin
        grant_d = winner;
        state_d = go ? ISSUE : DRAIN;
        pe_op_d = go ? win_op : pe_op_q;
      end
      DRAIN: if (pipe_empty) begin
        pe_op_d = grant_op;
        state_d = ISSUE;
      end
      default: begin
        beat_cnt_d = burst_end ? '0 : beat_cnt_q + CW'(accept);
        rr_ptr_d   = burst_end ? ((grant_q == IDW'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1) : rr_ptr_q;
        state_d    = burst_end ? ARB : ISSUE;
      end
    endcase
  end
  always_comb begin
    issue      = state_q == ISSUE;
    req_ready  = issue ? NUM_REQ'(1) << grant_q : '0;
    pe_in1     = issue ? req_data1[grant_q*PHIT +: PHIT] : '0;
    pe_in2     = issue ? req_data2[grant_q*PHIT +: PHIT] : '0;
    pe_tvalid1 = accept ? req_lanes[grant_q*SIMD +: SIMD] : '0;
    pe_tvalid2 = pe_tvalid1;
    pe_op      = pe_op_q;
    res_valid  = tag_v_q[LAT-1];
    res_id     = tag_v_q[LAT-1] ? tag_id_q[LAT-1] : '0;
    busy       = (state_q != ARB) || !pipe_empty;
  end
endmodule

// File: tb/tb_vpe_op_scheduler.sv
// tb_vpe_op_scheduler: directed bursts against a queue-based model of the scheduler,
// plus hand-computed grant/latency/drain expectations per scenario.
module tb_vpe_op_scheduler;
  localparam int N = 4, PHIT = 512, SIMD = 16, LAT = 4, OPW = 3, MB = 16, IDW = 2;
  logic clk = 0, rst = 0;
  logic [N-1:0] req_valid, req_last, req_ready;
  logic [N*OPW-1:0] req_op;
  logic [N*PHIT-1:0] req_data1, req_data2;
  logic [N*SIMD-1:0] req_lanes;
  logic [PHIT-1:0] pe_in1, pe_in2;
  logic [SIMD-1:0] pe_tvalid1, pe_tvalid2;
  logic [OPW-1:0] pe_op;
  logic res_valid, busy;
  logic [IDW-1:0] res_id;
  int tests = 0, fails = 0;

  vpe_op_scheduler #(.NUM_REQ(N), .PHIT(PHIT), .SIMD(SIMD), .LAT(LAT), .OPW(OPW), .MAX_BURST(MB)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_op(req_op), .req_last(req_last),
    .req_data1(req_data1), .req_data2(req_data2), .req_lanes(req_lanes), .req_ready(req_ready),
    .pe_in1(pe_in1), .pe_in2(pe_in2), .pe_tvalid1(pe_tvalid1), .pe_tvalid2(pe_tvalid2),
    .pe_op(pe_op), .res_valid(res_valid), .res_id(res_id), .busy(busy));

  always #5 clk = ~clk;

  task automatic cmp(string name, logic [PHIT-1:0] act, logic [PHIT-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Requester behaviour: queued bursts, optional bubble after a given beat count.
  typedef struct {int id; int len; int op; bit nolast;} burst_t;
  burst_t bq[$];
  int rem[N], done[N], bub_at[N], bub_len[N], bub_cnt[N], opv[N];
  bit nol[N];
  logic [N-1:0] acc;
  initial begin
    req_valid = '0; req_last = '0; req_op = '0; req_data1 = '0; req_data2 = '0; req_lanes = '0;
    for (int i = 0; i < N; i++) begin rem[i] = 0; done[i] = 0; bub_at[i] = -1; bub_len[i] = 0; bub_cnt[i] = 0; opv[i] = 0; nol[i] = 0; end
    forever begin
      @(negedge clk);
      acc = req_valid & req_ready;
      @(posedge clk); #1;
      if (!rst) bq.delete();
      for (int i = 0; i < N; i++) begin
        if (!rst) begin rem[i] = 0; done[i] = 0; bub_cnt[i] = 0; bub_at[i] = -1; acc[i] = 0; end
        if (acc[i]) begin rem[i]--; done[i]++; end
        bub_cnt[i] = (acc[i] && done[i] == bub_at[i]) ? bub_len[i] : (bub_cnt[i] > 0 ? bub_cnt[i] - 1 : 0);
        if (rem[i] == 0)
          for (int k = 0; k < bq.size(); k++)
            if (bq[k].id == i) begin
              rem[i] = bq[k].len; opv[i] = bq[k].op; nol[i] = bq[k].nolast;
              bq.delete(k);
              break;
            end
        req_valid[i] = rem[i] > 0 && bub_cnt[i] == 0;
        req_last[i]  = !nol[i] && rem[i] == 1;
        req_op[i*OPW +: OPW] = OPW'(opv[i]);
        req_data1[i*PHIT +: PHIT] = {16{32'(i * 1000 + done[i])}};
        req_data2[i*PHIT +: PHIT] = ~{16{32'(i * 1000 + done[i])}};
        req_lanes[i*SIMD +: SIMD] = SIMD'(32'hA5C3 ^ (done[i] << i));
      end
    end
  end

  // Model: state 0 idle/arbitrating, 1 waiting for drain, 2 issuing; pipe[0] is the newest owner, -1 = empty slot.
  int m_st = 0, m_ptr = 0, m_grant = 0, m_op = 0, m_cnt = 0;
  int pipe[$];
  bit m_acc, m_empty, m_iss;
  function automatic bit pipe_empty();
    foreach (pipe[k]) if (pipe[k] >= 0) return 0;
    return 1;
  endfunction
  function automatic int op_of(int g);
    return int'(req_op[g*OPW +: OPW]);
  endfunction
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_st = 0; m_ptr = 0; m_grant = 0; m_op = 0; m_cnt = 0;
      pipe.delete();
      repeat (LAT) pipe.push_back(-1);
    end else begin
      m_empty = pipe_empty();
      m_acc = m_st == 2 && req_valid[m_grant];
      pipe.push_front(m_acc ? m_grant : -1);
      void'(pipe.pop_back());
      case (m_st)
        0: for (int k = 0; k < N; k++)
             if (req_valid[(m_ptr + k) % N]) begin
               m_grant = (m_ptr + k) % N;
               if (op_of(m_grant) == m_op || m_empty) begin m_op = op_of(m_grant); m_st = 2; end
               else m_st = 1;
               break;
             end
        1: if (m_empty) begin m_op = op_of(m_grant); m_st = 2; end
        default: if (m_acc) begin
          m_cnt++;
          if (req_last[m_grant] || m_cnt == MB) begin m_ptr = (m_grant + 1) % N; m_cnt = 0; m_st = 0; end
        end
      endcase
    end
  end

  int rdy_log[$], acc_log[$], rv_log[$], op_log[$], tvz_log[$];
  int lid;
  always @(negedge clk) begin
    m_iss = m_st == 2;
    cmp("req_ready", PHIT'(req_ready), m_iss ? PHIT'(1) << m_grant : '0);
    cmp("pe_in1", pe_in1, m_iss ? req_data1[m_grant*PHIT +: PHIT] : '0);
    cmp("pe_in2", pe_in2, m_iss ? req_data2[m_grant*PHIT +: PHIT] : '0);
    cmp("pe_tvalid1", PHIT'(pe_tvalid1), (m_iss && req_valid[m_grant]) ? PHIT'(req_lanes[m_grant*SIMD +: SIMD]) : '0);
    cmp("pe_tvalid2", PHIT'(pe_tvalid2), (m_iss && req_valid[m_grant]) ? PHIT'(req_lanes[m_grant*SIMD +: SIMD]) : '0);
    cmp("pe_op", PHIT'(pe_op), PHIT'(m_op));
    cmp("res_valid", PHIT'(res_valid), PHIT'(pipe[LAT-1] >= 0));
    if (pipe[LAT-1] >= 0) cmp("res_id", PHIT'(res_id), PHIT'(pipe[LAT-1]));
    cmp("busy", PHIT'(busy), PHIT'(m_st != 0 || !pipe_empty()));
    lid = -1;
    for (int b = N - 1; b >= 0; b--) if (req_ready[b]) lid = b;
    rdy_log.push_back(lid);
    acc_log.push_back((lid >= 0 && req_valid[lid]) ? lid : -1);
    rv_log.push_back(res_valid ? int'(res_id) : -1);
    op_log.push_back(int'(pe_op));
    tvz_log.push_back(int'(req_ready != 0 && pe_tvalid1 == 0));
  end

  int run_id[$], run_len[$], gaps[$], exp_q[$];
  int r_first, r_last;
  task automatic runs(input int lg[$]);
    int prev = -1, gap = 0;
    run_id.delete(); run_len.delete(); gaps.delete(); r_first = -1; r_last = -1;
    foreach (lg[k]) begin
      if (lg[k] >= 0) begin
        if (lg[k] != prev) begin
          if (run_id.size() > 0) gaps.push_back(gap);
          run_id.push_back(lg[k]); run_len.push_back(1);
        end else run_len[run_len.size()-1] += 1;
        if (r_first < 0) r_first = k;
        r_last = k; gap = 0;
      end else gap++;
      prev = lg[k];
    end
  endtask
  task automatic chk_list(string name, input int act[$], input int exp[$]);
    cmp({name, "_n"}, PHIT'(act.size()), PHIT'(exp.size()));
    for (int k = 0; k < exp.size() && k < act.size(); k++)
      cmp($sformatf("%s[%0d]", name, k), PHIT'(act[k]), PHIT'(exp[k]));
  endtask
  task automatic clear_logs();
    rdy_log.delete(); acc_log.delete(); rv_log.delete(); op_log.delete(); tvz_log.delete();
  endtask
  task automatic do_reset();
    @(posedge clk); #2 rst = 0;
    repeat (2) @(posedge clk);
    #2 rst = 1;
    @(negedge clk);
    clear_logs();
  endtask
  task automatic push(int id, int len, int op, bit nl);
    bq.push_back('{id, len, op, nl});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int a, b, s;
    do_reset();
    // 1: single 4-beat burst, op 3
    push(0, 4, 3, 0);
    repeat (14) @(negedge clk);
    runs(rdy_log);
    a = r_first;
    exp_q = {0}; chk_list("t1_grant", run_id, exp_q);
    exp_q = {4}; chk_list("t1_len", run_len, exp_q);
    runs(rv_log);
    exp_q = {0}; chk_list("t1_res_id", run_id, exp_q);
    exp_q = {4}; chk_list("t1_res_len", run_len, exp_q);
    cmp("t1_latency", PHIT'(r_first - a), PHIT'(LAT));
    s = 0;
    for (int k = a; k <= r_last && k < op_log.size(); k++) if (op_log[k] != 3) s++;
    cmp("t1_op_held", PHIT'(s), '0);
    // 2: requesters 0 and 2, same op, alternating 2-beat bursts
    do_reset();
    push(0, 2, 1, 0); push(2, 2, 1, 0); push(0, 2, 1, 0); push(2, 2, 1, 0);
    repeat (20) @(negedge clk);
    runs(rdy_log);
    exp_q = {0, 2, 0, 2}; chk_list("t2_grant", run_id, exp_q);
    exp_q = {2, 2, 2, 2}; chk_list("t2_len", run_len, exp_q);
    exp_q = {1, 1, 1};    chk_list("t2_gap", gaps, exp_q);
    // 3: op change 1 -> 5 waits for the pipe to drain
    do_reset();
    push(0, 3, 1, 0); push(1, 2, 5, 0);
    repeat (25) @(negedge clk);
    runs(rdy_log);
    exp_q = {0, 1}; chk_list("t3_grant", run_id, exp_q);
    exp_q = {3, 2}; chk_list("t3_len", run_len, exp_q);
    exp_q = {5};    chk_list("t3_gap", gaps, exp_q);
    a = -1; b = -1;
    foreach (rv_log[k]) if (rv_log[k] == 0) a = k;
    foreach (op_log[k]) if (op_log[k] == 5 && b < 0) b = k;
    cmp("t3_op_after_drain", PHIT'(b - a), PHIT'(2));
    // 4: 40-beat stream without last, forced re-arbitration
    do_reset();
    push(3, 40, 2, 1);
    repeat (60) @(negedge clk);
    runs(acc_log);
    exp_q = {3, 3, 3};    chk_list("t4_grant", run_id, exp_q);
    exp_q = {16, 16, 8};  chk_list("t4_beats", run_len, exp_q);
    exp_q = {1, 1};       chk_list("t4_gap", gaps, exp_q);
    // 5: two-cycle bubble mid-burst
    do_reset();
    bub_at[1] = 3; bub_len[1] = 2;
    push(1, 6, 4, 0);
    repeat (25) @(negedge clk);
    runs(rdy_log);
    exp_q = {8}; chk_list("t5_ready_len", run_len, exp_q);
    s = 0;
    foreach (tvz_log[k]) s += tvz_log[k];
    cmp("t5_tvalid_gaps", PHIT'(s), PHIT'(2));
    runs(rv_log);
    exp_q = {3, 3}; chk_list("t5_res_len", run_len, exp_q);
    exp_q = {2};    chk_list("t5_res_gap", gaps, exp_q);
    // 6: reset mid-burst flushes tags and round-robin pointer
    do_reset();
    push(2, 2, 6, 0); push(2, 8, 6, 0);
    for (int k = 0; k < 60 && done[2] < 5; k++) @(negedge clk);
    cmp("t6_reach_burst", PHIT'(done[2] >= 5), PHIT'(1));
    @(posedge clk); #2 rst = 0;
    #1;
    cmp("t6_rst_ready", PHIT'(req_ready), '0);
    cmp("t6_rst_in1", pe_in1, '0);
    cmp("t6_rst_in2", pe_in2, '0);
    cmp("t6_rst_tv1", PHIT'(pe_tvalid1), '0);
    cmp("t6_rst_tv2", PHIT'(pe_tvalid2), '0);
    cmp("t6_rst_op", PHIT'(pe_op), '0);
    cmp("t6_rst_rv", PHIT'(res_valid), '0);
    cmp("t6_rst_id", PHIT'(res_id), '0);
    cmp("t6_rst_busy", PHIT'(busy), '0);
    repeat (2) @(posedge clk);
    #2 rst = 1;
    @(negedge clk);
    clear_logs();
    repeat (8) @(negedge clk);
    runs(rv_log);
    cmp("t6_no_flushed_res", PHIT'(run_id.size()), '0);
    clear_logs();
    push(1, 1, 6, 0); push(3, 1, 6, 0);
    repeat (10) @(negedge clk);
    runs(rdy_log);
    exp_q = {1, 3}; chk_list("t6_ptr_reset", run_id, exp_q);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
